vertex_integrator: RTL and testbench

VERTEX_INTEGRATOR -- requirements
Module: vertex_integrator

---
 rtl/vertex_integrator_pkg.sv | 36 +++
 rtl/vertex_integrator_sat_add.sv | 25 ++
 rtl/vertex_integrator.sv | 250 +++++++++++++++++++++++++
 tb/tb_vertex_integrator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vertex_integrator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vertex_integrator_pkg
// Brief    : Shared physics widths, integrator state encoding, signed saturation.
// Revision : 1.0
// ============================================================================
package vertex_integrator_pkg;

    localparam int FORCE_SIZE_DEF    = 8;
    localparam int POSITION_SIZE_DEF = 8;
    localparam int VELOCITY_SIZE_DEF = 7;

    typedef enum logic [1:0] {
        ST_ACCUM     = 2'd0,
        ST_INTEGRATE = 2'd1,
        ST_DONE      = 2'd2
    } state_t;

    // Clamp a wide signed value into the signed range of a 'width'-bit field.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                    input int                 width);
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -max_v - 32'sd1;
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vertex_integrator_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sat_add
// Brief    : Signed adder whose result clamps to the signed range of OUT_W.
// Revision : 1.0
// ============================================================================
module sat_add
    import vertex_integrator_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int OUT_W = 8
)(
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [OUT_W-1:0] sum_o
);

    logic signed [31:0] sum_w;

    assign sum_w = 32'(a_i) + 32'(b_i);
    assign sum_o = OUT_W'(saturate(sum_w, OUT_W));

endmodule
`default_nettype wire

// File: rtl/vertex_integrator.sv
`default_nettype none
// ============================================================================
// Module   : vertex_integrator
// Brief    : Accumulates spring forces per vertex, then integrates all vertices
//            one per cycle with semi-implicit Euler and saturating arithmetic.
// Revision : 1.0
// ============================================================================
module vertex_integrator
    import vertex_integrator_pkg::*;
#(
    parameter int NUM_VERTICES  = 8,
    parameter int FORCE_SIZE    = FORCE_SIZE_DEF,
    parameter int POSITION_SIZE = POSITION_SIZE_DEF,
    parameter int VELOCITY_SIZE = VELOCITY_SIZE_DEF,
    parameter int MASS_SHIFT    = 2,
    parameter int GRAVITY       = -1,
    localparam int IDX_W        = $clog2(NUM_VERTICES)
)(
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            force_valid,
    input  logic signed [FORCE_SIZE-1:0]    force_x,
    input  logic signed [FORCE_SIZE-1:0]    force_y,
    input  logic [IDX_W-1:0]                idx1,
    input  logic [IDX_W-1:0]                idx2,
    output logic                            force_ready,
    input  logic                            step_start,
    output logic                            step_done,
    input  logic [NUM_VERTICES-1:0]         pin_mask,
    input  logic                            load_valid,
    input  logic [IDX_W-1:0]                load_idx,
    input  logic signed [POSITION_SIZE-1:0] load_x,
    input  logic signed [POSITION_SIZE-1:0] load_y,
    input  logic [IDX_W-1:0]                rd_idx,
    output logic signed [POSITION_SIZE-1:0] rd_x,
    output logic signed [POSITION_SIZE-1:0] rd_y,
    output logic signed [VELOCITY_SIZE-1:0] rd_vx,
    output logic signed [VELOCITY_SIZE-1:0] rd_vy
);

    localparam int ACC_SIZE = FORCE_SIZE + 4;
    // Shifted accumulator plus gravity needs headroom before velocity clamping.
    localparam int DV_W     = ACC_SIZE + 2;

    state_t                         state_q;
    logic [IDX_W-1:0]               cnt_q;
    logic                           step_done_q;

    logic signed [POSITION_SIZE-1:0] pos_x_q [NUM_VERTICES];
    logic signed [POSITION_SIZE-1:0] pos_y_q [NUM_VERTICES];
    logic signed [VELOCITY_SIZE-1:0] vel_x_q [NUM_VERTICES];
    logic signed [VELOCITY_SIZE-1:0] vel_y_q [NUM_VERTICES];
    logic signed [ACC_SIZE-1:0]      acc_x_q [NUM_VERTICES];
    logic signed [ACC_SIZE-1:0]      acc_y_q [NUM_VERTICES];
    logic signed [ACC_SIZE-1:0]      acc_x_d [NUM_VERTICES];
    logic signed [ACC_SIZE-1:0]      acc_y_d [NUM_VERTICES];

    logic [NUM_VERTICES-1:0]        load_hit_w;
    logic [NUM_VERTICES-1:0]        proc_hit_w;

    logic signed [ACC_SIZE-1:0]     fx_pos_w;
    logic signed [ACC_SIZE-1:0]     fy_pos_w;
    logic signed [ACC_SIZE-1:0]     fx_neg_w;
    logic signed [ACC_SIZE-1:0]     fy_neg_w;
    logic                           pair_ok_w;

    assign fx_pos_w  = ACC_SIZE'(force_x);
    assign fy_pos_w  = ACC_SIZE'(force_y);
    assign fx_neg_w  = -fx_pos_w;
    assign fy_neg_w  = -fy_pos_w;
    assign pair_ok_w = force_valid && (state_q == ST_ACCUM) && (idx1 != idx2);

    for (genvar i = 0; i < NUM_VERTICES; i++) begin : g_vertex
        logic                       hit1_w;
        logic                       hit2_w;
        logic signed [ACC_SIZE-1:0] dx_w;
        logic signed [ACC_SIZE-1:0] dy_w;

        assign hit1_w = pair_ok_w && (idx1 == IDX_W'(i));
        assign hit2_w = pair_ok_w && (idx2 == IDX_W'(i));
        assign dx_w   = hit1_w ? fx_pos_w : (hit2_w ? fx_neg_w : '0);
        assign dy_w   = hit1_w ? fy_pos_w : (hit2_w ? fy_neg_w : '0);

        assign load_hit_w[i] = load_valid && (state_q == ST_ACCUM) && (load_idx == IDX_W'(i));
        assign proc_hit_w[i] = (state_q == ST_INTEGRATE) && (cnt_q == IDX_W'(i));

        sat_add #(.A_W(ACC_SIZE), .B_W(ACC_SIZE), .OUT_W(ACC_SIZE)) u_acc_x (
            .a_i   (acc_x_q[i]),
            .b_i   (dx_w),
            .sum_o (acc_x_d[i])
        );

        sat_add #(.A_W(ACC_SIZE), .B_W(ACC_SIZE), .OUT_W(ACC_SIZE)) u_acc_y (
            .a_i   (acc_y_q[i]),
            .b_i   (dy_w),
            .sum_o (acc_y_d[i])
        );
    end

    logic signed [POSITION_SIZE-1:0] cur_px_w;
    logic signed [POSITION_SIZE-1:0] cur_py_w;
    logic signed [VELOCITY_SIZE-1:0] cur_vx_w;
    logic signed [VELOCITY_SIZE-1:0] cur_vy_w;
    logic signed [ACC_SIZE-1:0]      cur_ax_w;
    logic signed [ACC_SIZE-1:0]      cur_ay_w;

    always_comb begin
        cur_px_w = '0;
        cur_py_w = '0;
        cur_vx_w = '0;
        cur_vy_w = '0;
        cur_ax_w = '0;
        cur_ay_w = '0;
        for (int i = 0; i < NUM_VERTICES; i++) begin
            if (cnt_q == IDX_W'(i)) begin
                cur_px_w = pos_x_q[i];
                cur_py_w = pos_y_q[i];
                cur_vx_w = vel_x_q[i];
                cur_vy_w = vel_y_q[i];
                cur_ax_w = acc_x_q[i];
                cur_ay_w = acc_y_q[i];
            end
        end
    end

    logic signed [ACC_SIZE-1:0]      shx_w;
    logic signed [ACC_SIZE-1:0]      shy_w;
    logic signed [DV_W-1:0]          dvx_w;
    logic signed [DV_W-1:0]          dvy_w;
    logic signed [VELOCITY_SIZE-1:0] vx_d;
    logic signed [VELOCITY_SIZE-1:0] vy_d;
    logic signed [POSITION_SIZE-1:0] px_d;
    logic signed [POSITION_SIZE-1:0] py_d;

    assign shx_w = cur_ax_w >>> MASS_SHIFT;
    assign shy_w = cur_ay_w >>> MASS_SHIFT;
    assign dvx_w = DV_W'(shx_w);
    assign dvy_w = DV_W'(shy_w) + DV_W'(GRAVITY);

    sat_add #(.A_W(VELOCITY_SIZE), .B_W(DV_W), .OUT_W(VELOCITY_SIZE)) u_vel_x (
        .a_i   (cur_vx_w),
        .b_i   (dvx_w),
        .sum_o (vx_d)
    );

    sat_add #(.A_W(VELOCITY_SIZE), .B_W(DV_W), .OUT_W(VELOCITY_SIZE)) u_vel_y (
        .a_i   (cur_vy_w),
        .b_i   (dvy_w),
        .sum_o (vy_d)
    );

    // Position advances with the freshly updated velocity.
    sat_add #(.A_W(POSITION_SIZE), .B_W(VELOCITY_SIZE), .OUT_W(POSITION_SIZE)) u_pos_x (
        .a_i   (cur_px_w),
        .b_i   (vx_d),
        .sum_o (px_d)
    );

    sat_add #(.A_W(POSITION_SIZE), .B_W(VELOCITY_SIZE), .OUT_W(POSITION_SIZE)) u_pos_y (
        .a_i   (cur_py_w),
        .b_i   (vy_d),
        .sum_o (py_d)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            step_done_q <= 1'b0;
            for (int i = 0; i < NUM_VERTICES; i++) begin
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
                vel_x_q[i] <= '0;
                vel_y_q[i] <= '0;
                acc_x_q[i] <= '0;
                acc_y_q[i] <= '0;
            end
        end else begin
            step_done_q <= 1'b0;
            for (int i = 0; i < NUM_VERTICES; i++) begin
                if (load_hit_w[i]) begin
                    pos_x_q[i] <= load_x;
                    pos_y_q[i] <= load_y;
                    vel_x_q[i] <= '0;
                    vel_y_q[i] <= '0;
                    acc_x_q[i] <= '0;
                    acc_y_q[i] <= '0;
                end else if (proc_hit_w[i]) begin
                    acc_x_q[i] <= '0;
                    acc_y_q[i] <= '0;
                    if (pin_mask[i]) begin
                        vel_x_q[i] <= '0;
                        vel_y_q[i] <= '0;
                    end else begin
                        vel_x_q[i] <= vx_d;
                        vel_y_q[i] <= vy_d;
                        pos_x_q[i] <= px_d;
                        pos_y_q[i] <= py_d;
                    end
                end else begin
                    acc_x_q[i] <= acc_x_d[i];
                    acc_y_q[i] <= acc_y_d[i];
                end
            end

            case (state_q)
                ST_ACCUM: begin
                    if (step_start) begin
                        state_q <= ST_INTEGRATE;
                        cnt_q   <= '0;
                    end
                end
                ST_INTEGRATE: begin
                    if (cnt_q == IDX_W'(NUM_VERTICES - 1)) begin
                        state_q     <= ST_DONE;
                        step_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_ACCUM;
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    assign force_ready = (state_q == ST_ACCUM);
    assign step_done   = step_done_q;

    always_comb begin
        rd_x  = '0;
        rd_y  = '0;
        rd_vx = '0;
        rd_vy = '0;
        for (int i = 0; i < NUM_VERTICES; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_x  = pos_x_q[i];
                rd_y  = pos_y_q[i];
                rd_vx = vel_x_q[i];
                rd_vy = vel_y_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vertex_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_vertex_integrator
// Brief    : Directed scoreboard bench; one DUT without gravity/shift, one with
//            default physics constants, sharing the same stimulus.
// Revision : 1.0
// ============================================================================
module tb_vertex_integrator;

    localparam int N      = 8;
    localparam int K_VTX  = 0;
    localparam int K_VTXG = 1;
    localparam int K_RDY  = 2;
    localparam int K_DONE = 3;
    localparam int K_TMO  = 4;

    typedef struct {
        int    kind;
        int    idx;
        int    x;
        int    y;
        int    vx;
        int    vy;
        string name;
    } exp_t;

    logic              clk_in      = 1'b0;
    logic              rst_in      = 1'b1;
    logic              force_valid = 1'b0;
    logic signed [7:0] force_x     = '0;
    logic signed [7:0] force_y     = '0;
    logic [2:0]        idx1        = '0;
    logic [2:0]        idx2        = '0;
    logic              step_start  = 1'b0;
    logic [7:0]        pin_mask    = '0;
    logic              load_valid  = 1'b0;
    logic [2:0]        load_idx    = '0;
    logic signed [7:0] load_x      = '0;
    logic signed [7:0] load_y      = '0;
    logic [2:0]        rd_idx      = '0;

    logic              force_ready, step_done, g_force_ready, g_step_done;
    logic signed [7:0] rd_x, rd_y, g_rd_x, g_rd_y;
    logic signed [6:0] rd_vx, rd_vy, g_rd_vx, g_rd_vy;

    vertex_integrator #(
        .NUM_VERTICES(8), .FORCE_SIZE(8), .POSITION_SIZE(8), .VELOCITY_SIZE(7),
        .MASS_SHIFT(0), .GRAVITY(0)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .force_valid(force_valid),
        .force_x(force_x), .force_y(force_y), .idx1(idx1), .idx2(idx2),
        .force_ready(force_ready), .step_start(step_start), .step_done(step_done),
        .pin_mask(pin_mask), .load_valid(load_valid), .load_idx(load_idx),
        .load_x(load_x), .load_y(load_y), .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_y(rd_y), .rd_vx(rd_vx), .rd_vy(rd_vy)
    );

    vertex_integrator dut_g (
        .clk_in(clk_in), .rst_in(rst_in), .force_valid(force_valid),
        .force_x(force_x), .force_y(force_y), .idx1(idx1), .idx2(idx2),
        .force_ready(g_force_ready), .step_start(step_start), .step_done(g_step_done),
        .pin_mask(pin_mask), .load_valid(load_valid), .load_idx(load_idx),
        .load_x(load_x), .load_y(load_y), .rd_idx(rd_idx),
        .rd_x(g_rd_x), .rd_y(g_rd_y), .rd_vx(g_rd_vx), .rd_vy(g_rd_vy)
    );

    always #50 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    exp_t step_q[$];
    exp_t now_q[$];
    int   done_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   req_cnt  = 0;
    int   srv_cnt  = 0;
    int   done_cnt = 0;

    function automatic exp_t mk(input int kind, input int idx, input int x, input int y,
                                input int vx, input int vy, input string name);
        exp_t e;
        e.kind = kind; e.idx = idx; e.x = x; e.y = y; e.vx = vx; e.vy = vy; e.name = name;
        return e;
    endfunction

    function automatic int bit_val(input logic b);
        return (b === 1'b1) ? 1 : ((b === 1'b0) ? 0 : -1);
    endfunction

    // Compares one expectation against live DUT outputs; used by the monitor only.
    task automatic check_entry(input exp_t e);
        int ii, ax, ay, avx, avy;
        checks++;
        if (e.kind == K_VTX || e.kind == K_VTXG) begin
            ii = e.idx;
            rd_idx = ii[2:0];
            #1;
            if (e.kind == K_VTX) begin
                ax = int'(rd_x); ay = int'(rd_y); avx = int'(rd_vx); avy = int'(rd_vy);
            end else begin
                ax = int'(g_rd_x); ay = int'(g_rd_y); avx = int'(g_rd_vx); avy = int'(g_rd_vy);
            end
            if (ax != e.x || ay != e.y || avx != e.vx || avy != e.vy) begin
                errors++;
                $display("FAIL %s v%0d: got pos(%0d,%0d) vel(%0d,%0d) want pos(%0d,%0d) vel(%0d,%0d)",
                         e.name, e.idx, ax, ay, avx, avy, e.x, e.y, e.vx, e.vy);
            end
        end else if (e.kind == K_RDY) begin
            ax = bit_val(force_ready);
            if (ax != e.x) begin
                errors++;
                $display("FAIL %s: force_ready got %0d want %0d", e.name, ax, e.x);
            end
        end else if (e.kind == K_DONE) begin
            ax = bit_val(step_done);
            if (ax != e.x) begin
                errors++;
                $display("FAIL %s: step_done got %0d want %0d", e.name, ax, e.x);
            end
        end else begin
            errors++;
            $display("FAIL %s: step_done never arrived within the cycle budget", e.name);
        end
    endtask

    initial begin : monitor
        int exp_cyc;
        forever begin
            @(negedge clk_in);
            if (step_done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step_done: pulse at cycle %0d, want none", cyc);
                end else begin
                    exp_cyc = done_q.pop_front();
                    if (exp_cyc != cyc) begin
                        errors++;
                        $display("FAIL step_latency: step_done at cycle %0d want %0d", cyc, exp_cyc);
                    end
                end
                while (step_q.size() > 0) check_entry(step_q.pop_front());
                done_cnt++;
            end
            if (req_cnt != srv_cnt) begin
                while (now_q.size() > 0) check_entry(now_q.pop_front());
                srv_cnt = req_cnt;
            end
        end
    end

    // Stimulus tasks are entered on a falling edge and return on a falling edge.
    task automatic flush_now();
        req_cnt++;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic load_v(input int idx, input int x, input int y);
        load_valid = 1'b1;
        load_idx   = idx[2:0];
        load_x     = x[7:0];
        load_y     = y[7:0];
        @(negedge clk_in);
        load_valid = 1'b0;
    endtask

    task automatic apply_force(input int i1, input int i2, input int fx, input int fy);
        force_valid = 1'b1;
        idx1        = i1[2:0];
        idx2        = i2[2:0];
        force_x     = fx[7:0];
        force_y     = fy[7:0];
        @(negedge clk_in);
        force_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int k = 0; k < 40 && done_cnt == d0; k++) @(negedge clk_in);
        if (done_cnt == d0) begin
            now_q.push_back(mk(K_TMO, 0, 0, 0, 0, 0, name));
            flush_now();
        end
    endtask

    task automatic run_step(input string name);
        int d0;
        d0 = done_cnt;
        step_start = 1'b1;
        done_q.push_back(cyc + N + 1);
        @(negedge clk_in);
        step_start = 1'b0;
        wait_done(d0, name);
    endtask

    task automatic push_all_zero(input string name);
        now_q.push_back(mk(K_RDY, 0, 1, 0, 0, 0, {name, "_force_ready"}));
        now_q.push_back(mk(K_DONE, 0, 0, 0, 0, 0, {name, "_step_done"}));
        for (int i = 0; i < N; i++) begin
            now_q.push_back(mk(K_VTX, i, 0, 0, 0, 0, name));
            now_q.push_back(mk(K_VTXG, i, 0, 0, 0, 0, {name, "_g"}));
        end
    endtask

    initial begin : stimulus
        int d0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;

        push_all_zero("reset");
        flush_now();

        // Opposite forces on a two-vertex spring.
        load_v(0, 2, 2);
        load_v(1, 2, 4);
        apply_force(0, 1, 0, 2);
        step_q.push_back(mk(K_VTX, 0, 2, 4, 0, 2, "spring_v0"));
        step_q.push_back(mk(K_VTX, 1, 2, 2, 0, -2, "spring_v1"));
        step_q.push_back(mk(K_VTXG, 0, 2, 1, 0, -1, "gravity_v0"));
        step_q.push_back(mk(K_VTXG, 1, 2, 2, 0, -2, "gravity_floor_v1"));
        step_q.push_back(mk(K_VTXG, 2, 0, -1, 0, -1, "gravity_v2"));
        run_step("spring_step");

        // Velocity and position saturation with a pinned far endpoint.
        pin_mask = 8'h80;
        load_v(0, 0, 0);
        load_v(7, 7, -7);
        for (int s = 0; s < 3; s++) begin
            apply_force(0, 7, 100, 0);
            step_q.push_back(mk(K_VTX, 0, (s == 2) ? 127 : 63 * (s + 1), 0, 63, 0, "sat_v0"));
            step_q.push_back(mk(K_VTX, 7, 7, -7, 0, 0, "pinned_v7"));
            run_step("sat_step");
        end

        // Pinned vertex ignores force and has its accumulator cleared.
        pin_mask = 8'h84;
        load_v(2, 5, 5);
        load_v(3, 0, 0);
        apply_force(2, 3, 10, -10);
        step_q.push_back(mk(K_VTX, 2, 5, 5, 0, 0, "pinned_v2"));
        step_q.push_back(mk(K_VTX, 3, -10, 10, -10, 10, "neg_end_v3"));
        run_step("pin_step");
        pin_mask = 8'h00;
        load_v(6, 1, 1);
        apply_force(6, 6, 50, 50);
        step_q.push_back(mk(K_VTX, 2, 5, 5, 0, 0, "acc_cleared_v2"));
        step_q.push_back(mk(K_VTX, 3, -20, 20, -10, 10, "coast_v3"));
        step_q.push_back(mk(K_VTX, 6, 1, 1, 0, 0, "self_spring_v6"));
        run_step("unpin_step");

        // Force coincident with step_start counts; traffic during integration is dropped.
        load_v(4, 0, 0);
        load_v(5, 0, 0);
        load_v(6, 0, 0);
        step_q.push_back(mk(K_VTX, 4, 3, 1, 3, 1, "coincident_v4"));
        step_q.push_back(mk(K_VTX, 5, -3, -1, -3, -1, "coincident_v5"));
        step_q.push_back(mk(K_VTX, 6, 0, 0, 0, 0, "coincident_v6"));
        d0 = done_cnt;
        force_valid = 1'b1; idx1 = 3'd4; idx2 = 3'd5; force_x = 8'sd3; force_y = 8'sd1;
        step_start  = 1'b1;
        done_q.push_back(cyc + N + 1);
        @(negedge clk_in);
        step_start  = 1'b0;
        force_x     = 8'sd20; force_y = 8'sd20;
        load_valid  = 1'b1; load_idx = 3'd6; load_x = 8'sd50; load_y = 8'sd50;
        step_start  = 1'b1;
        now_q.push_back(mk(K_RDY, 0, 0, 0, 0, 0, "integrate_force_ready"));
        flush_now();
        force_valid = 1'b0;
        load_valid  = 1'b0;
        step_start  = 1'b0;
        wait_done(d0, "coincident_step");
        step_q.push_back(mk(K_VTX, 4, 6, 2, 3, 1, "dropped_force_v4"));
        step_q.push_back(mk(K_VTX, 5, -6, -2, -3, -1, "dropped_force_v5"));
        step_q.push_back(mk(K_VTX, 6, 0, 0, 0, 0, "dropped_load_v6"));
        run_step("after_drop_step");

        // Reset mid-integration aborts the step without a done pulse.
        step_start = 1'b1;
        @(negedge clk_in);
        step_start = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        push_all_zero("abort");
        flush_now();
        repeat (15) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
